dmem_copy_engine: RTL

- Word-granular block-copy initiator that drives the single-port data memory's CLK/WE/A/WD/RD interface.
- On a START pulse it copies LEN words from SRC to DST through the combinational-read, posedge-write memory port.
- Accumulates a running sum of the copied words as a checksum.
- Sits beside the processor datapath; the processor is stalled by BUSY while the engine owns the memory port.

---
 rtl/dmem_copy_engine.sv | 102 ++++++++++
 1 files changed

// File: rtl/dmem_copy_engine.sv
// Word-granular block-copy initiator for the single-port data memory.
// Copies LEN words SRC->DST one read/write pair at a time and sums the written words into CHK.
module dmem_copy_engine #(
  parameter int W  = 32,
  parameter int LW = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [W-1:0]  SRC,
  input  logic [W-1:0]  DST,
  input  logic [LW-1:0] LEN,
  output logic          BUSY,
  output logic          DONE,
  output logic [W-1:0]  CHK,
  output logic          MEM_WE,
  output logic [W-1:0]  MEM_A,
  output logic [W-1:0]  MEM_WD,
  input  logic [W-1:0]  MEM_RD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FIN
  } state_t;

  state_t        state;
  logic [W-1:0]  src_q;
  logic [W-1:0]  dst_q;
  logic [W-1:0]  data_q;
  logic [LW-1:0] cnt_q;

  // The write-data port is the read buffer itself, so it holds in every state.
  assign MEM_WD = data_q;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      CHK    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_A  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            src_q <= SRC;
            dst_q <= DST;
            cnt_q <= LEN;
            CHK   <= '0;
            if (LEN != '0) begin
              state <= S_RD;
              BUSY  <= 1'b1;
              MEM_A <= SRC;
            end else begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end
          end
        end
        S_RD: begin
          data_q <= MEM_RD;
          MEM_A  <= dst_q;
          MEM_WE <= 1'b1;
          state  <= S_WR;
        end
        S_WR: begin
          src_q  <= src_q + W'(1);
          dst_q  <= dst_q + W'(1);
          CHK    <= CHK + data_q;
          cnt_q  <= cnt_q - LW'(1);
          MEM_WE <= 1'b0;
          if (cnt_q == LW'(1)) begin
            state <= S_FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            MEM_A <= '0;
          end else begin
            state <= S_RD;
            MEM_A <= src_q + W'(1);
          end
        end
        S_FIN: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
